// File: rtl/phy_reset_sequencer.sv
// rtl/phy_reset_sequencer.sv - staggered multi-port PHY reset release with link supervision
// Ports:
//   clk        : single clock for all logic
//   rst        : synchronous, active-high reset
//   link_up    : per-port link status, already synchronous to clk
//   reset_req  : per-port single-cycle soft reset request
//   phy_rst_n  : per-port active-low PHY reset, registered
//   port_ready : per-port released-and-linked status, registered
//   port_fault : per-port retries-exhausted flag, registered
module phy_reset_sequencer #(
  parameter int NUM_PORTS           = 4,
  parameter int RESET_CYCLES        = 524288,
  parameter int STAGGER_CYCLES      = 1024,
  parameter int LINK_TIMEOUT_CYCLES = 16777216,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_WIDTH           = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] link_up,
  input  logic [NUM_PORTS-1:0] reset_req,
  output logic [NUM_PORTS-1:0] phy_rst_n,
  output logic [NUM_PORTS-1:0] port_ready,
  output logic [NUM_PORTS-1:0] port_fault
);

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int GW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  localparam bit                   TIMEOUT_EN = (LINK_TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  =
    (RESET_CYCLES > 0) ? CNT_WIDTH'(RESET_CYCLES - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST  =
    (LINK_TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(LINK_TIMEOUT_CYCLES - 1) : '0;
  localparam logic [RW-1:0]        RETRY_MAX  = RW'(MAX_RETRIES);
  // Guard is checked for zero on the grant cycle, so loading STAGGER-1 puts
  // the next possible release exactly STAGGER clocks after this one.
  localparam logic [GW-1:0]        GUARD_LOAD =
    (STAGGER_CYCLES > 1) ? GW'(STAGGER_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_PENDING,
    ST_LINK_WAIT,
    ST_UP,
    ST_FAULT
  } state_t;

  state_t               state_q   [NUM_PORTS];
  state_t               state_d   [NUM_PORTS];
  logic [CNT_WIDTH-1:0] timer_q   [NUM_PORTS];
  logic [CNT_WIDTH-1:0] timer_d   [NUM_PORTS];
  logic [RW-1:0]        retries_q [NUM_PORTS];
  logic [RW-1:0]        retries_d [NUM_PORTS];
  logic [GW-1:0]        guard_q;
  logic [GW-1:0]        guard_d;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic                 found;
  logic                 released;

  always_comb begin
    eligible = '0;
    grant    = '0;
    found    = 1'b0;
    released = 1'b0;
    guard_d  = guard_q;

    // A port whose hold expires this cycle competes immediately; if it loses
    // it parks in PENDING.
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = (state_q[i] == ST_PENDING) ||
                    ((state_q[i] == ST_HOLD) && (timer_q[i] == HOLD_LAST));
    end

    // Lowest eligible index wins; a soft reset on the winner voids the slot
    // rather than handing it to the next port.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (eligible[i] && !found && (guard_q == '0)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        released = !reset_req[i];
      end
    end

    if (released) begin
      guard_d = GUARD_LOAD;
    end else if (guard_q != '0) begin
      guard_d = guard_q - GW'(1);
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i]   = state_q[i];
      timer_d[i]   = timer_q[i];
      retries_d[i] = retries_q[i];
      if (reset_req[i]) begin
        state_d[i]   = ST_HOLD;
        timer_d[i]   = '0;
        retries_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_HOLD, ST_PENDING: begin
            if (grant[i]) begin
              state_d[i] = ST_LINK_WAIT;
              timer_d[i] = '0;
            end else if (eligible[i]) begin
              state_d[i] = ST_PENDING;
            end else begin
              timer_d[i] = timer_q[i] + CNT_WIDTH'(1);
            end
          end
          ST_LINK_WAIT: begin
            if (link_up[i]) begin
              state_d[i]   = ST_UP;
              timer_d[i]   = '0;
              retries_d[i] = '0;
            end else if (TIMEOUT_EN && (timer_q[i] == WAIT_LAST)) begin
              timer_d[i] = '0;
              if (retries_q[i] < RETRY_MAX) begin
                state_d[i]   = ST_HOLD;
                retries_d[i] = retries_q[i] + RW'(1);
              end else begin
                state_d[i] = ST_FAULT;
              end
            end else if (TIMEOUT_EN) begin
              timer_d[i] = timer_q[i] + CNT_WIDTH'(1);
            end
          end
          ST_UP: begin
            if (!link_up[i]) begin
              state_d[i] = ST_LINK_WAIT;
              timer_d[i] = '0;
            end
          end
          ST_FAULT: begin
            state_d[i] = ST_FAULT;
          end
          default: begin
            state_d[i] = ST_HOLD;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      guard_q    <= '0;
      phy_rst_n  <= '0;
      port_ready <= '0;
      port_fault <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]   <= ST_HOLD;
        timer_q[i]   <= '0;
        retries_q[i] <= '0;
      end
    end else begin
      guard_q <= guard_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]    <= state_d[i];
        timer_q[i]    <= timer_d[i];
        retries_q[i]  <= retries_d[i];
        phy_rst_n[i]  <= (state_d[i] == ST_LINK_WAIT) || (state_d[i] == ST_UP) ||
                         (state_d[i] == ST_FAULT);
        port_ready[i] <= (state_d[i] == ST_UP);
        port_fault[i] <= (state_d[i] == ST_FAULT);
      end
    end
  end

endmodule

// File: doc/phy_reset_sequencer.md
Name: phy_reset_sequencer

Overview:
Parametrised successor to the single fixed PHY reset counter in the network interface top level. It drives reset for NUM_PORTS external PHYs or transceivers and staggers their release so inrush and PLL lock events do not coincide. It supervises each port's link after release: a port that does not reach link-up within a timeout is re-reset, and after a bounded number of retries it is flagged as faulted. Sits beside the MAC wrappers and feeds LED and status logic.

Parameters:
NUM_PORTS, 4, number of supervised ports.
RESET_CYCLES, 524288, clocks each PHY reset is held low per reset episode.
STAGGER_CYCLES, 1024, minimum clocks between any two successive reset releases.
LINK_TIMEOUT_CYCLES, 16777216, clocks allowed from release to link_up; 0 disables timeout/retry.
MAX_RETRIES, 3, timeout-triggered re-resets before a port is declared faulted.
CNT_WIDTH, 25, per-port timer width; must hold max(RESET_CYCLES, LINK_TIMEOUT_CYCLES).

Ports:
clk  input  1  single clock for all logic.
rst  input  1  synchronous, active-high reset.
link_up  input  NUM_PORTS  per-port link status, already synchronous to clk.
reset_req  input  NUM_PORTS  per-port single-cycle soft reset request.
phy_rst_n  output  NUM_PORTS  active-low PHY reset, registered.
port_ready  output  NUM_PORTS  port released and link up, registered.
port_fault  output  NUM_PORTS  retries exhausted, registered.

Behaviour:
- Reset values: phy_rst_n=0, port_ready=0, port_fault=0, every port in HOLD with timer=0 and retries=0, guard timer=0.
- Each port has its own FSM:
  - HOLD: phy_rst_n=0; timer counts up; at RESET_CYCLES-1 go to PENDING.
  - PENDING: phy_rst_n=0; wait for a release grant.
  - LINK_WAIT: phy_rst_n=1; timer counts from 0.
  - UP: phy_rst_n=1; port_ready=1.
  - FAULT: phy_rst_n=1; port_fault=1.
- Release arbitration:
  - One shared guard timer.
  - A grant is possible only when the guard is idle (0).
  - Among PENDING ports, the lowest index wins; exactly one grant per cycle.
  - The granted port enters LINK_WAIT, and the guard loads so the next release is exactly STAGGER_CYCLES clocks later.
  - STAGGER_CYCLES=0 still permits only one release per cycle.
- Release timing after rst: port i phy_rst_n rises exactly RESET_CYCLES + i*STAGGER_CYCLES clocks after the first clock with rst low.
- LINK_WAIT transitions:
  - link_up=1: go to UP. port_ready rises 1 clock after link_up is sampled high. retries clears on entering UP.
  - Timer reaches LINK_TIMEOUT_CYCLES-1 with link_up low and retries<MAX_RETRIES: retries++, go to HOLD with timer cleared, phy_rst_n falls next clock.
  - Same timeout with retries==MAX_RETRIES: go to FAULT.
  - If link_up rises on the timeout cycle, link_up wins.
- UP: link_up=0 sampled: go to LINK_WAIT with timer cleared; port_ready falls next clock; retries stays 0.
- FAULT: exit only via reset_req or rst.
- reset_req[i] has highest priority in every state:
  - Next state is HOLD with timer and retries cleared.
  - port_ready, port_fault and phy_rst_n for that port go to 0 next clock.
  - A request arriving while already in HOLD or PENDING restarts the hold.
  - A request on the same cycle the port is granted cancels the grant; the guard is not loaded.
- The guard timer is shared; a re-reset port waits for it like any other.
- rst mid-operation returns all state to reset values on the next edge, regardless of state.
- All outputs come directly from flops. No combinational input-to-output paths.

Test Plan:
Common bench parameters: NUM_PORTS=3, RESET_CYCLES=16, STAGGER_CYCLES=8, LINK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Boot: deassert rst at cycle 0, link_up=0 -> phy_rst_n rises at cycles 16, 24, 32 for ports 0, 1, 2; port_ready=0 and port_fault=0 throughout.
2. Link-up: link_up[0]=1 at cycle 20 -> port_ready[0]=1 at cycle 21. Drop link_up[0] at cycle 40 -> port_ready[0]=0 at 41 and phy_rst_n[0] stays 1.
3. Retry/fault: link_up[1] never asserts -> phy_rst_n[1] falls at cycle 56 and rises at 72, falls at 104 and rises at 120, then port_fault[1]=1 at 152 with phy_rst_n[1]=1 held.
4. Contention: all ports UP, reset_req[2] and reset_req[0] pulsed the same cycle T -> both held 16 clocks; phy_rst_n[0] rises at T+17 and phy_rst_n[2] at T+25.
5. Fault recovery: reset_req[1] while port 1 is in FAULT -> port_fault[1]=0 and phy_rst_n[1]=0 next clock; full hold, then release via guard.
6. Mid-run rst: assert rst for 1 clock while ports are in mixed states -> all outputs at reset values next clock; boot timing of scenario 1 repeats from rst deassertion.
